ram_arbiter: RTL
================

# ram_arbiter

Round-robin arbiter sharing one single-port 32x8 RAM between two clients: port 0 (binary-search engine reads) and port 1 (host loader reads/writes). Issues at most one RAM access per cycle and routes registered read data back to the issuing client after the RAM's fixed read latency. This replaces per-client wait states with a single read-return tracker. It sits between the search/loader controllers and the RAM macro.

## Interface
- ADDR_W, 5, RAM address width
- DATA_W, 8, RAM data width
- RD_LAT, 2, cycles from issued read to valid ram_q (1..4)
- CLOCK_50  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- req0, req1  in  1 each  access request, held until granted
- we0, we1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  ADDR_W each  access address
- wdata0, wdata1  in  DATA_W each  write data
- lock0, lock1  in  1 each  hold ownership after grant (see Configuration)
- gnt0, gnt1  out  1 each  combinational grant; access issues this cycle
- rvalid0, rvalid1  out  1 each  read data valid for that client
- rdata  out  DATA_W  read data, shared; qualified by rvalid0/rvalid1
- ram_addr  out  ADDR_W  to RAM
- ram_wdata  out  DATA_W  to RAM
- ram_wren  out  1  to RAM
- ram_q  in  DATA_W  RAM registered output

## Operation
- Grant: gnt0, gnt1 are mutually exclusive and never asserted without the matching req.
- Arbitration uses a 1-bit priority pointer prio, reset to 0:
  - Only one req: that client is granted.
  - Both req: client prio is granted.
  - After any grant to client n, prio becomes ~n on the next cycle.
- RAM mux: ram_addr, ram_wdata and ram_wren follow the granted client. ram_wren = granted & we.
  - With no grant: ram_wren = 0, ram_addr = addr0, ram_wdata = 0.
- Read return: each granted read pushes {valid=1, owner=n} into an RD_LAT-deep shift pipe. Each write or idle cycle pushes {valid=0}.
- Pipe output: rvalid<owner> = 1 for one cycle, with rdata = ram_q. rdata = ram_q at all times.
- Writes produce no rvalid.
- Back-to-back reads from alternating clients return in issue order, one per cycle.
- FSM states: ARB, LOCK0, LOCK1.
  - ARB: normal arbitration.
  - ARB -> LOCKn when client n is granted with lockn = 1.
  - LOCKn: only client n may be granted. The other client's req is stalled. prio is not updated.
  - LOCKn -> ARB on the first cycle where lockn = 0, with no grant in that cycle. Arbitration resumes the next cycle.
- Reset mid-operation: FSM -> ARB, prio -> 0, pipe cleared. In-flight reads are discarded and never assert rvalid.

## Timing
- Reset values: gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, ram_wren = 0, state ARB, prio 0.
- Grant latency: 0 cycles (same cycle as req, if winning).
- Read latency: a read granted in cycle t gives rvalid in cycle t+RD_LAT.
- Write takes effect at the RAM on the edge ending grant cycle t.
- Throughput: 1 access/cycle. With both clients continuously requesting and unlocked, grants strictly alternate 0,1,0,1.
- Request held while not granted: client must keep req/we/addr/wdata stable.

## Configuration
- RAM_ARB_LOCK_EN defined: lock0/lock1 honoured; LOCK0/LOCK1 states exist.
- Not defined: lock inputs ignored, FSM permanently ARB, pure round-robin.

## Structure
- Package ram_arb_pkg holds:
  - ADDR_W, DATA_W, RD_LAT defaults
  - owner_t (1-bit enum: OWN_SEARCH, OWN_LOADER)
  - arb_state_t (ARB, LOCK0, LOCK1)
  - ret_entry_t struct {valid, owner}
- One sub-module, rd_return_pipe: RD_LAT-deep shift register of ret_entry_t with synchronous reset. Outputs the tail entry.

## Test plan
- Reset held 3 cycles with req0 = req1 = 1 -> all gnt/rvalid/ram_wren 0. First post-reset cycle grants client 0.
- Port 1 writes 0xA5 to addr 7, then port 0 reads addr 7 -> gnt1, then gnt0 next cycle. rvalid0 with rdata = 0xA5 exactly RD_LAT cycles after gnt0. rvalid1 never high.
- Both clients read continuously (addr0 = 3, addr1 = 9, preloaded 0x11/0x22) -> grants alternate 0,1,0,1. rvalid alternates with rdata 0x11, 0x22, ...
- Reset asserted one cycle after a granted read -> no rvalid ever appears for that read.
- With RAM_ARB_LOCK_EN: client 1 granted with lock1 = 1 for 4 cycles while req0 = 1 -> gnt1 four cycles, gnt0 low throughout. lock1 drops -> one idle cycle, then gnt0.
- Without RAM_ARB_LOCK_EN: same stimulus -> grants alternate; lock ignored.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-client RAM arbiter.
// Pure declarations; no timing or flow-control behaviour lives here.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RD_LAT = 2;

  typedef enum logic {
    OWN_SEARCH = 1'b0,
    OWN_LOADER = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } ret_entry_t;

endpackage

// File: rtl/rd_return_pipe.sv
// Read-return tracker: DEPTH-stage shift of {valid, owner}; tail appears DEPTH cycles after push.
// No backpressure: one entry enters and one leaves every cycle; sync reset empties it.
module rd_return_pipe
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_RD_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  ret_entry_t din,
  output ret_entry_t dout
);

  ret_entry_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '{valid: 1'b0, owner: OWN_SEARCH};
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin share of one single-port RAM between search (0) and loader (1); grant same cycle, read data RD_LAT later.
// Losing client holds its request; RAM_ARB_LOCK_EN enables lock0/lock1 ownership hold.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  arb_state_t state;
  logic       prio;
  ret_entry_t push;
  ret_entry_t tail;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!Reset) begin
      case (state)
        // Dropping the lock ends ownership with one idle cycle, no grant.
        LOCK0: gnt0 = req0 & lock0;
        LOCK1: gnt1 = req1 & lock1;
        default: begin
          if (req0 && req1) begin
            gnt0 = ~prio;
            gnt1 = prio;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state <= ARB;
      prio  <= 1'b0;
    end else begin
      if (state == ARB) begin
        if (gnt0) prio <= 1'b1;
        else if (gnt1) prio <= 1'b0;
      end
`ifdef RAM_ARB_LOCK_EN
      case (state)
        ARB: begin
          if (gnt0 && lock0) state <= LOCK0;
          else if (gnt1 && lock1) state <= LOCK1;
        end
        LOCK0:   if (!lock0) state <= ARB;
        LOCK1:   if (!lock1) state <= ARB;
        default: state <= ARB;
      endcase
`else
      state <= ARB;
`endif
    end
  end

`ifndef RAM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
`endif

  assign ram_wren  = (gnt0 & we0) | (gnt1 & we1);
  assign ram_addr  = gnt1 ? addr1 : addr0;
  assign ram_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

  assign push.valid = (gnt0 & ~we0) | (gnt1 & ~we1);
  assign push.owner = gnt1 ? OWN_LOADER : OWN_SEARCH;

  rd_return_pipe #(.DEPTH(RD_LAT)) u_ret (
    .clk  (CLOCK_50),
    .rst  (Reset),
    .din  (push),
    .dout (tail)
  );

  // Gated by Reset so a read still in flight when reset hits never surfaces.
  assign rvalid0 = ~Reset & tail.valid & (tail.owner == OWN_SEARCH);
  assign rvalid1 = ~Reset & tail.valid & (tail.owner == OWN_LOADER);
  assign rdata   = ram_q;

endmodule
